// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, mux encodings and state type for multicycle_control
// Purpose: constants and types used by multicycle_control and op_decode.
// Ports: none (package).
package ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_BEQ = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_TRAP
  } stateT;

  typedef struct packed {
    logic r;
    logic i;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic illegal;
  } opClassT;

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - combinational opcode-to-instruction-class decoder
// Purpose: one-hot class of a 7-bit opcode; jal is legal only when ENABLE_JAL != 0.
// Ports:
//   op       in   7-bit opcode
//   opClass  out  one-hot class {r, i, lw, sw, beq, jal, illegal}
module op_decode
  import ctrl_pkg::*;
#(
  parameter int ENABLE_JAL = 0
) (
  input  logic [6:0] op,
  output opClassT    opClass
);

  always_comb begin
    opClass = '0;
    case (op)
      OP_R:    opClass.r   = 1'b1;
      OP_I:    opClass.i   = 1'b1;
      OP_LW:   opClass.lw  = 1'b1;
      OP_SW:   opClass.sw  = 1'b1;
      OP_BEQ:  opClass.beq = 1'b1;
      OP_JAL: begin
        if (ENABLE_JAL != 0) opClass.jal = 1'b1;
        else                 opClass.illegal = 1'b1;
      end
      default: opClass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RISC-V control FSM with memory handshake and traps
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH, drives Moore datapath controls,
//          traps on illegal opcodes or memory timeouts, counts retired instructions.
// Ports:
//   clk_i, rst_i (sync, active-high), start_i, Op_i, NoOp_i, mem_ack_i   inputs
//   mem_req_o, mem_we_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o,
//   ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegWrite_o, MemtoReg_o                datapath controls
//   busy_o, illegal_o, timeout_o, instret_o                              status
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ENABLE_JAL  = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       Op_i,
  input  logic             NoOp_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  stateT             state, nextState;
  logic [6:0]        opReg;
  logic [6:0]        decOp;
  opClassT           opClass;
  logic [WAIT_W-1:0] waitCnt;
  logic              waitExpired;
  logic              retire;
  logic              setIllegal;
  logic              setTimeout;

  // DECODE classifies the live opcode; later states use the copy latched in DECODE.
  assign decOp = (state == S_DECODE) ? Op_i : opReg;

  op_decode #(
    .ENABLE_JAL(ENABLE_JAL)
  ) uDecode (
    .op     (decOp),
    .opClass(opClass)
  );

  // True in the last un-acked request cycle allowed; an ack in that cycle still wins.
  assign waitExpired = (MEM_TIMEOUT > 0) && (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));

  assign busy_o = (state != S_IDLE) && (state != S_TRAP);

  always_comb begin
    nextState     = state;
    retire        = 1'b0;
    setIllegal    = 1'b0;
    setTimeout    = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_RS2;
    ALUOp_o       = ALUOP_ADD;
    RegWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) nextState = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        ALUOp_o   = ALUOP_ADD;
        if (mem_ack_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          nextState = S_DECODE;
        end else if (waitExpired) begin
          nextState  = S_TRAP;
          setTimeout = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB_o = SRCB_IMM;
        if (NoOp_i) begin
          nextState = S_FETCH;
        end else if (opClass.r || opClass.i || opClass.lw || opClass.sw) begin
          nextState = S_EXEC;
        end else if (opClass.beq) begin
          nextState = S_BRANCH;
        end else if (opClass.jal) begin
          nextState = S_WB;
        end else if (opClass.illegal) begin
          nextState  = S_TRAP;
          setIllegal = 1'b1;
        end
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        if (opClass.r) begin
          ALUSrcB_o = SRCB_RS2;
          ALUOp_o   = ALUOP_R;
        end else begin
          ALUSrcB_o = SRCB_IMM;
          ALUOp_o   = ALUOP_ADD;
        end
        nextState = (opClass.lw || opClass.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        IorD_o    = 1'b1;
        mem_we_o  = opClass.sw;
        if (mem_ack_i) begin
          if (opClass.sw) begin
            nextState = S_FETCH;
            retire    = 1'b1;
          end else begin
            nextState = S_WB;
          end
        end else if (waitExpired) begin
          nextState  = S_TRAP;
          setTimeout = 1'b1;
        end
      end
      S_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = opClass.lw;
        PCWrite_o  = opClass.jal;
        nextState  = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUSrcB_o     = SRCB_RS2;
        ALUOp_o       = ALUOP_BEQ;
        PCWriteCond_o = 1'b1;
        nextState     = S_FETCH;
        retire        = 1'b1;
      end
      S_TRAP: begin
        nextState = S_TRAP;
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      opReg     <= '0;
      waitCnt   <= '0;
      instret_o <= '0;
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= nextState;
      if (state == S_DECODE) opReg <= Op_i;
      // Any state change restarts the count, so FETCH and MEM always begin at zero.
      if (nextState != state) waitCnt <= '0;
      else if (mem_req_o)     waitCnt <= waitCnt + WAIT_W'(1);
      if (retire) instret_o <= instret_o + CNT_W'(1);
      illegal_o <= illegal_o | setIllegal;
      timeout_o <= timeout_o | setTimeout;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum {C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_ILL} clsT;

  typedef struct {
    string       name;
    bit          start;
    logic [6:0]  op;
    bit          noop;
    bit          ack;
    logic [15:0] exp;
    int          ret;
  } vecT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], start[2], NoOp[2], ack[2];
  logic [6:0] Op[2];
  logic       memReq[2], memWe[2], IorD[2], IRWrite[2], PCWrite[2], PCWriteCond[2];
  logic       ALUSrcA[2], RegWrite[2], MemtoReg[2], busy[2], illegal[2], timeout[2];
  logic [1:0] ALUSrcB[2], ALUOp[2];
  logic [31:0] instret0;
  logic [3:0]  instret1;

  // dut 0: timeout 4, jal illegal, 32-bit counter. dut 1: no timeout, jal legal, 4-bit counter.
  multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_JAL(0), .CNT_W(32)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .Op_i(Op[0]), .NoOp_i(NoOp[0]),
    .mem_ack_i(ack[0]), .mem_req_o(memReq[0]), .mem_we_o(memWe[0]), .IorD_o(IorD[0]),
    .IRWrite_o(IRWrite[0]), .PCWrite_o(PCWrite[0]), .PCWriteCond_o(PCWriteCond[0]),
    .ALUSrcA_o(ALUSrcA[0]), .ALUSrcB_o(ALUSrcB[0]), .ALUOp_o(ALUOp[0]),
    .RegWrite_o(RegWrite[0]), .MemtoReg_o(MemtoReg[0]), .busy_o(busy[0]),
    .illegal_o(illegal[0]), .timeout_o(timeout[0]), .instret_o(instret0));

  multicycle_control #(.MEM_TIMEOUT(0), .ENABLE_JAL(1), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .Op_i(Op[1]), .NoOp_i(NoOp[1]),
    .mem_ack_i(ack[1]), .mem_req_o(memReq[1]), .mem_we_o(memWe[1]), .IorD_o(IorD[1]),
    .IRWrite_o(IRWrite[1]), .PCWrite_o(PCWrite[1]), .PCWriteCond_o(PCWriteCond[1]),
    .ALUSrcA_o(ALUSrcA[1]), .ALUSrcB_o(ALUSrcB[1]), .ALUOp_o(ALUOp[1]),
    .RegWrite_o(RegWrite[1]), .MemtoReg_o(MemtoReg[1]), .busy_o(busy[1]),
    .illegal_o(illegal[1]), .timeout_o(timeout[1]), .instret_o(instret1));

  int nTests = 0;
  int nFail  = 0;
  int retired[2];
  bit illegalFlag[2], timeoutFlag[2];
  vecT tbl[$];

  logic [15:0] eFetchW, eFetchA, eDec, eExR, eExI, eMemLw, eMemSw, eWb, eWbLw, eWbJal, eBr;

  // Layout: req we iord irw pcw pcwc srcA srcB[2] aluOp[2] rw m2r busy illegal timeout
  function automatic logic [15:0] obs(int d);
    return {memReq[d], memWe[d], IorD[d], IRWrite[d], PCWrite[d], PCWriteCond[d], ALUSrcA[d],
            ALUSrcB[d], ALUOp[d], RegWrite[d], MemtoReg[d], busy[d], illegal[d], timeout[d]};
  endfunction

  function automatic logic [15:0] ctl(bit req, bit we, bit iord, bit irw, bit pcw, bit pcwc,
                                      bit srcA, logic [1:0] srcB, logic [1:0] aop, bit rw, bit m2r);
    return {req, we, iord, irw, pcw, pcwc, srcA, srcB, aop, rw, m2r, 1'b1, 2'b00};
  endfunction

  function automatic logic [15:0] flags(int d);
    return {14'd0, illegalFlag[d], timeoutFlag[d]};
  endfunction

  function automatic int tmo(int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic logic [31:0] retMasked(int d, int n);
    logic [31:0] v = 32'(n);
    return (d == 0) ? v : (v & 32'hf);
  endfunction

  function automatic logic [31:0] retGot(int d);
    return (d == 0) ? instret0 : {28'd0, instret1};
  endfunction

  function automatic clsT classify(int d, logic [6:0] op);
    case (op)
      OP_R:    return C_R;
      OP_I:    return C_I;
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_BEQ:  return C_BEQ;
      OP_JAL:  return (d == 1) ? C_JAL : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  task automatic check(string name, int d, logic [31:0] got, logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s (dut%0d): got %h, expected %h", name, d, got, exp);
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1 ns later.
  task automatic step(int d, string name, logic [15:0] exp);
    #1;
    check({name, "/ctl"}, d, 32'(obs(d)), 32'(exp));
    check({name, "/instret"}, d, retGot(d), retMasked(d, retired[d]));
    @(negedge clk);
  endtask

  task automatic add(string name, bit st, logic [6:0] op, bit noop, bit a, logic [15:0] exp, int ret);
    vecT v;
    v.name = name; v.start = st; v.op = op; v.noop = noop; v.ack = a; v.exp = exp; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic boot(int d);
    rst[d] = 1'b1; start[d] = 1'b1; ack[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0; start[d] = 1'b0; ack[d] = 1'($urandom);
    illegalFlag[d] = 1'b0; timeoutFlag[d] = 1'b0; retired[d] = 0;
    step(d, "boot_idle", 16'h0000);
    start[d] = 1'b1;
    step(d, "boot_start", 16'h0000);
  endtask

  // A request phase: nWait un-acked cycles, then an ack, unless the timeout cuts it short.
  task automatic waitPhase(int d, string name, int nWait, logic [15:0] eWait, logic [15:0] eAck,
                           inout int cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c <= nWait; c++) begin
      if (tmo(d) > 0 && c >= tmo(d)) break;
      ack[d] = (c == nWait);
      step(d, name, ((c == nWait) ? eAck : eWait) | flags(d));
      cyc++;
      ok = (c == nWait);
    end
    ack[d] = 1'($urandom);
    if (!ok) timeoutFlag[d] = 1'b1;
  endtask

  // Runs one instruction from FETCH entry; cyc counts cycles spent until the next FETCH or TRAP.
  task automatic runInstr(int d, logic [6:0] op, bit noop, int fWait, int mWait,
                          output int cyc, output bit trapped);
    clsT cls = classify(d, op);
    bit ok;
    cyc = 0;
    trapped = 1'b1;
    start[d] = 1'($urandom);
    waitPhase(d, "fetch", fWait, eFetchW, eFetchA, cyc, ok);
    if (!ok) return;
    Op[d] = op; NoOp[d] = noop;
    step(d, "decode", eDec | flags(d));
    cyc++;
    Op[d] = 7'($urandom); NoOp[d] = 1'($urandom);
    trapped = 1'b0;
    if (noop) return;
    case (cls)
      C_ILL: begin illegalFlag[d] = 1'b1; trapped = 1'b1; end
      C_BEQ: begin step(d, "branch", eBr | flags(d)); cyc++; retired[d]++; end
      C_JAL: begin step(d, "wb_jal", eWbJal | flags(d)); cyc++; retired[d]++; end
      C_R: begin
        step(d, "exec_r", eExR | flags(d));
        step(d, "wb_r", eWb | flags(d));
        cyc += 2; retired[d]++;
      end
      C_I: begin
        step(d, "exec_i", eExI | flags(d));
        step(d, "wb_i", eWb | flags(d));
        cyc += 2; retired[d]++;
      end
      C_LW: begin
        step(d, "exec_lw", eExI | flags(d));
        cyc++;
        waitPhase(d, "mem_lw", mWait, eMemLw, eMemLw, cyc, ok);
        if (!ok) trapped = 1'b1;
        else begin step(d, "wb_lw", eWbLw | flags(d)); cyc++; retired[d]++; end
      end
      default: begin
        step(d, "exec_sw", eExI | flags(d));
        cyc++;
        waitPhase(d, "mem_sw", mWait, eMemSw, eMemSw, cyc, ok);
        if (!ok) trapped = 1'b1;
        else retired[d]++;
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  trapped;
    logic [6:0] op;
    int  fw, mw;

    eFetchW = ctl(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    eFetchA = ctl(1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    eDec    = ctl(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
    eExR    = ctl(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
    eExI    = ctl(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
    eMemLw  = ctl(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    eMemSw  = ctl(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    eWb     = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    eWbLw   = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    eWbJal  = ctl(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0);
    eBr     = ctl(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b11, 0, 0);

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; NoOp[d] = 1'b0; ack[d] = 1'b0; Op[d] = 7'd0;
      retired[d] = 0; illegalFlag[d] = 1'b0; timeoutFlag[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Directed cycle table on dut0: R, sw, beq, a squashed bubble, then a FETCH timeout.
    add("reset",         0, 7'd0,   0, 1, 16'h0000, 0);
    add("idle_start",    1, 7'd0,   0, 0, 16'h0000, 0);
    add("r_fetch",       0, 7'd0,   0, 1, eFetchA,  0);
    add("r_decode",      0, OP_R,   0, 0, eDec,     0);
    add("r_exec",        0, 7'h7f,  1, 0, eExR,     0);
    add("r_wb",          1, 7'd0,   0, 1, eWb,      0);
    add("sw_fetch_wait", 0, 7'd0,   0, 0, eFetchW,  1);
    add("sw_fetch",      0, 7'd0,   0, 1, eFetchA,  1);
    add("sw_decode",     0, OP_SW,  0, 0, eDec,     1);
    add("sw_exec",       0, OP_R,   0, 0, eExI,     1);
    add("sw_mem_wait",   0, OP_LW,  0, 0, eMemSw,   1);
    add("sw_mem",        0, 7'd0,   0, 1, eMemSw,   1);
    add("beq_fetch",     0, 7'd0,   0, 1, eFetchA,  2);
    add("beq_decode",    0, OP_BEQ, 0, 0, eDec,     2);
    add("beq_branch",    0, 7'd0,   0, 0, eBr,      2);
    add("noop_fetch",    0, 7'd0,   0, 1, eFetchA,  3);
    add("noop_decode",   0, OP_LW,  1, 0, eDec,     3);
    add("to_fetch0",     0, 7'd0,   0, 0, eFetchW,  3);
    add("to_fetch1",     0, 7'd0,   0, 0, eFetchW,  3);
    add("to_fetch2",     0, 7'd0,   0, 0, eFetchW,  3);
    add("to_fetch3",     0, 7'd0,   0, 0, eFetchW,  3);
    add("to_trap",       1, 7'd0,   0, 1, 16'h0001, 3);
    add("to_trap_hold",  1, 7'd0,   0, 1, 16'h0001, 3);
    for (int k = 0; k < tbl.size(); k++) begin
      start[0] = tbl[k].start; Op[0] = tbl[k].op; NoOp[0] = tbl[k].noop; ack[0] = tbl[k].ack;
      retired[0] = tbl[k].ret;
      step(0, tbl[k].name, tbl[k].exp);
    end
    step(1, "reset_dut1", 16'h0000);

    // Ack in the final allowed FETCH cycle beats the timeout.
    boot(0);
    runInstr(0, OP_I, 1'b0, 3, 0, cyc, trapped);
    check("ack_last_cycle_trapped", 0, 32'(trapped), 32'd0);
    check("i_cycles_with_3_waits", 0, 32'(cyc), 32'd7);

    // lw with three un-acked MEM cycles: 8 cycles from FETCH entry to retire.
    runInstr(0, OP_LW, 1'b0, 0, 3, cyc, trapped);
    check("lw_cycles", 0, 32'(cyc), 32'd8);

    // sw timing out in MEM.
    runInstr(0, OP_SW, 1'b0, 0, 4, cyc, trapped);
    check("sw_mem_timeout_trapped", 0, 32'(trapped), 32'd1);
    ack[0] = 1'b1;
    step(0, "mem_timeout_trap", 16'h0001);

    // jal is illegal when disabled.
    boot(0);
    runInstr(0, OP_JAL, 1'b0, 0, 0, cyc, trapped);
    check("jal_disabled_trapped", 0, 32'(trapped), 32'd1);
    step(0, "jal_illegal_trap", 16'h0002);

    // Reset while a lw is waiting in MEM clears everything at the next edge.
    boot(0);
    runInstr(0, OP_R, 1'b0, 0, 0, cyc, trapped);
    check("r_cycles", 0, 32'(cyc), 32'd4);
    ack[0] = 1'b1;
    step(0, "rm_fetch", eFetchA);
    Op[0] = OP_LW; NoOp[0] = 1'b0;
    step(0, "rm_decode", eDec);
    step(0, "rm_exec", eExI);
    ack[0] = 1'b0;
    step(0, "rm_mem", eMemLw);
    rst[0] = 1'b1; start[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    retired[0] = 0;
    step(0, "rm_after_reset", 16'h0000);

    // jal enabled on dut1, and long waits never trap without a timeout.
    boot(1);
    runInstr(1, OP_JAL, 1'b0, 0, 0, cyc, trapped);
    check("jal_cycles", 1, 32'(cyc), 32'd3);
    runInstr(1, OP_LW, 1'b0, 7, 9, cyc, trapped);
    check("no_timeout_trapped", 1, 32'(trapped), 32'd0);
    check("no_timeout_cycles", 1, 32'(cyc), 32'd21);

    // Randomized instruction streams against the procedural model.
    for (int d = 0; d < 2; d++) begin
      boot(d);
      for (int n = 0; n < 80; n++) begin
        case ($urandom_range(0, 7))
          0: op = OP_R;
          1: op = OP_I;
          2: op = OP_LW;
          3: op = OP_SW;
          4: op = OP_BEQ;
          5: op = OP_JAL;
          6: op = OP_R;
          default: op = 7'($urandom);
        endcase
        fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
        mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
        runInstr(d, op, ($urandom_range(0, 7) == 0), fw, mw, cyc, trapped);
        if (trapped) begin
          start[d] = 1'b1; ack[d] = 1'b1;
          step(d, "rand_trap", flags(d));
          step(d, "rand_trap_hold", flags(d));
          boot(d);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
